// File: rtl/sgm_pkg.sv
// sgm_pkg: shared defaults, width helper and pipeline marker type for the SGM raster stages
package sgm_pkg;
  localparam int PIXEL_DEPTH = 7;
  localparam int FRAME_WIDTH = 640;
  localparam int BLOCK_HEIGHT = 8;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int X_W = clog2_min1(FRAME_WIDTH);
  localparam int Y_W = clog2_min1(BLOCK_HEIGHT);
  typedef struct packed {
    logic line_end;
    logic band_end;
  } marks_t;
endpackage

// File: rtl/row_line_ram.sv
// row_line_ram: one image row of one bank, single write port, synchronous read port
// clk: clock; i_we/i_waddr/i_wdata: write port; i_re/i_raddr: read request; o_rdata: data one cycle after i_re
module row_line_ram #(
  parameter int depth = 640,
  parameter int width = 7,
  parameter int aw = 10
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_re,
  input  logic [aw-1:0]    i_raddr,
  output logic [width-1:0] o_rdata
);
  logic [width-1:0] r_mem [depth];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/column_to_raster.sv
// column_to_raster: ping-pong band buffer turning pixel columns back into a raster stream
// clk/rst: clock, async active-high reset
// in_valid/in_ready/inColumn: one column per beat, row i at [pixel_depth*i +: pixel_depth]
// out_valid/out_ready/outData: one raster pixel per beat
// out_line_end/out_band_end: last pixel of a row / of the band
module column_to_raster
  import sgm_pkg::*;
#(
  parameter int pixel_depth = PIXEL_DEPTH,
  parameter int frame_width = FRAME_WIDTH,
  parameter int block_height = BLOCK_HEIGHT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [block_height*pixel_depth-1:0] inColumn,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [pixel_depth-1:0]              outData,
  output logic                                out_line_end,
  output logic                                out_band_end
);
  localparam int XW = clog2_min1(frame_width);
  localparam int YW = clog2_min1(block_height);
  localparam logic [XW-1:0] X_LAST = XW'(frame_width - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(block_height - 1);

  logic                   r_wr_bank, r_rd_bank;
  logic [1:0]             r_full;
  logic [XW-1:0]          r_wr_x, r_rd_x;
  logic [YW-1:0]          r_rd_y;
  logic                   r_s1_valid, r_s1_bank;
  logic [YW-1:0]          r_s1_y;
  marks_t                 r_s1_mk;
  logic                   r_sk_valid;
  logic [pixel_depth-1:0] r_sk_data;
  marks_t                 r_sk_mk;

  logic                   w_wr_en, w_wr_last, w_adv, w_fetch, w_rd_last;
  logic [1:0]             w_set, w_clr;
  logic [pixel_depth-1:0] w_rd_data [2][block_height];
  logic [pixel_depth-1:0] w_s1_data;

  assign in_ready  = !r_full[r_wr_bank];
  assign w_wr_en   = in_valid && in_ready;
  assign w_wr_last = w_wr_en && r_wr_x == X_LAST;
  // Output register can take a new pixel this edge
  assign w_adv     = !out_valid || out_ready;
  assign w_fetch   = r_full[r_rd_bank] && w_adv;
  assign w_rd_last = w_fetch && r_rd_y == Y_LAST && r_rd_x == X_LAST;
  assign w_set     = {w_wr_last && r_wr_bank, w_wr_last && !r_wr_bank};
  assign w_clr     = {w_rd_last && r_rd_bank, w_rd_last && !r_rd_bank};
  assign w_s1_data = w_rd_data[r_s1_bank][r_s1_y];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar i = 0; i < block_height; i++) begin : g_row
      row_line_ram #(.depth(frame_width), .width(pixel_depth), .aw(XW)) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en && r_wr_bank == 1'(b)),
        .i_waddr (r_wr_x),
        .i_wdata (inColumn[pixel_depth*i +: pixel_depth]),
        .i_re    (w_fetch && r_rd_bank == 1'(b) && r_rd_y == YW'(i)),
        .i_raddr (r_rd_x),
        .o_rdata (w_rd_data[b][i])
      );
    end
  end

  // A pixel leaving the RAM while the output is stalled parks in the skid
  // register; no fetch is issued on a stalled edge, so skid and stage 1 are
  // never occupied together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_full       <= '0;
      r_wr_x       <= '0;
      r_rd_x       <= '0;
      r_rd_y       <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_bank    <= 1'b0;
      r_s1_y       <= '0;
      r_s1_mk      <= '0;
      r_sk_valid   <= 1'b0;
      r_sk_data    <= '0;
      r_sk_mk      <= '0;
      out_valid    <= 1'b0;
      outData      <= '0;
      out_line_end <= 1'b0;
      out_band_end <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_x    <= w_wr_last ? '0 : r_wr_x + 1'b1;
        r_wr_bank <= r_wr_bank ^ w_wr_last;
      end
      if (w_fetch) begin
        r_rd_x    <= (r_rd_x == X_LAST) ? '0 : r_rd_x + 1'b1;
        r_rd_y    <= (r_rd_x != X_LAST) ? r_rd_y : w_rd_last ? '0 : r_rd_y + 1'b1;
        r_rd_bank <= r_rd_bank ^ w_rd_last;
        r_s1_bank <= r_rd_bank;
        r_s1_y    <= r_rd_y;
        r_s1_mk   <= '{line_end: r_rd_x == X_LAST, band_end: w_rd_last};
      end
      r_full     <= (r_full | w_set) & ~w_clr;
      r_s1_valid <= w_fetch;
      if (w_adv) r_sk_valid <= 1'b0;
      else if (r_s1_valid) begin
        r_sk_valid <= 1'b1;
        r_sk_data  <= w_s1_data;
        r_sk_mk    <= r_s1_mk;
      end
      if (w_adv) begin
        out_valid <= r_sk_valid || r_s1_valid;
        if (r_sk_valid) begin
          outData      <= r_sk_data;
          out_line_end <= r_sk_mk.line_end;
          out_band_end <= r_sk_mk.band_end;
        end else if (r_s1_valid) begin
          outData      <= w_s1_data;
          out_line_end <= r_s1_mk.line_end;
          out_band_end <= r_s1_mk.band_end;
        end
      end
    end
  end
endmodule

// File: tb/tb_column_to_raster.sv
// tb_column_to_raster: directed bench for a 4x2x8 instance and a default 640x8x7 instance
module tb_column_to_raster;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic s_iv, s_ir, s_ov, s_or, s_le, s_be;
  logic [15:0] s_col;
  logic [7:0] s_od;
  logic d_iv, d_ir, d_ov, d_or, d_le, d_be;
  logic [55:0] d_col;
  logic [6:0] d_od;

  column_to_raster #(.pixel_depth(8), .frame_width(4), .block_height(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .inColumn(s_col),
    .out_valid(s_ov), .out_ready(s_or), .outData(s_od),
    .out_line_end(s_le), .out_band_end(s_be)
  );
  column_to_raster dut_d (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .inColumn(d_col),
    .out_valid(d_ov), .out_ready(d_or), .outData(d_od),
    .out_line_end(d_le), .out_band_end(d_be)
  );

  int n_tot = 0;
  int n_bad = 0;
  int d_cnt = 0;
  logic [9:0] s_q[$];
  logic [8:0] d_q[$];
  logic s_stall = 1'b0;
  logic [9:0] s_hold = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix(input int k, input int r, input int x);
    return 8'(k * 64 + r * 16 + x);
  endfunction

  always @(negedge clk) begin
    if (rst) s_stall <= 1'b0;
    else begin
      if (s_stall) chk("s_hold", {s_ov, s_le, s_be, s_od}, {1'b1, s_hold});
      if (s_ov && s_or) begin
        if (s_q.size() == 0) chk("s_extra", {1'b1, s_le, s_be, s_od}, 11'h0);
        else chk("s_pix", {s_le, s_be, s_od}, s_q.pop_front());
      end
      s_stall <= s_ov && !s_or;
      s_hold  <= {s_le, s_be, s_od};
    end
  end

  always @(negedge clk) begin
    if (!rst && d_ov && d_or) begin
      d_cnt <= d_cnt + 1;
      if (d_q.size() == 0) chk("d_extra", {1'b1, d_le, d_be, d_od}, 10'h0);
      else chk("d_pix", {d_le, d_be, d_od}, d_q.pop_front());
    end
  end

  task automatic put_s(input logic [15:0] c);
    int t = 0;
    s_col = c;
    s_iv = 1'b1;
    while (!s_ir && t < 300) begin
      tick;
      t++;
    end
    if (!s_ir) chk("s_accept", s_ir, 1);
    tick;
    s_iv = 1'b0;
  endtask

  task automatic band_s(input int k);
    for (int r = 0; r < 2; r++)
      for (int x = 0; x < 4; x++)
        s_q.push_back({x == 3, r == 1 && x == 3, pix(k, r, x)});
    for (int x = 0; x < 4; x++) put_s({pix(k, 1, x), pix(k, 0, x)});
  endtask

  task automatic drain_s;
    int t = 0;
    while ((s_q.size() != 0 || s_ov) && t < 400) begin
      tick;
      t++;
    end
    chk("s_drain", s_q.size(), 0);
  endtask

  task automatic put_d(input logic [55:0] c);
    int t = 0;
    d_col = c;
    d_iv = 1'b1;
    while (!d_ir && t < 6000) begin
      tick;
      t++;
    end
    if (!d_ir) chk("d_accept", d_ir, 1);
    tick;
    d_iv = 1'b0;
  endtask

  task automatic band_d;
    logic [55:0] cols [640];
    for (int x = 0; x < 640; x++) cols[x] = 56'({$urandom(), $urandom()});
    for (int r = 0; r < 8; r++)
      for (int x = 0; x < 640; x++)
        d_q.push_back({x == 639, r == 7 && x == 639, cols[x][7*r +: 7]});
    for (int x = 0; x < 640; x++) put_d(cols[x]);
  endtask

  initial begin
    int v;
    int t;
    s_iv = 0; s_or = 0; s_col = '0;
    d_iv = 0; d_or = 1; d_col = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_async_rdy", s_ir, 1);
    chk("rst_async_ov", s_ov, 0);
    chk("rst_async_od", s_od, 0);
    chk("rst_async_d_ov", d_ov, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick;
    chk("rst_rdy", s_ir, 1);
    chk("rst_ov", s_ov, 0);
    chk("rst_od", s_od, 0);
    chk("rst_le_be", {s_le, s_be}, 2'b00);

    // first band, full rate, two-edge latency
    s_or = 1;
    band_s(0);
    chk("lat0", s_ov, 0);
    tick;
    chk("lat1", s_ov, 0);
    tick;
    chk("lat2", s_ov, 1);
    chk("first_pix", s_od, 8'h00);
    repeat (3) tick;
    chk("pix03", {s_le, s_be, s_od}, {2'b10, 8'h03});
    repeat (4) tick;
    chk("pix13", {s_le, s_be, s_od}, {2'b11, 8'h13});
    drain_s;

    // both banks full with output stalled, then release
    s_or = 0;
    band_s(1);
    band_s(2);
    chk("full_both", s_ir, 0);
    repeat (3) tick;
    chk("full_both_hold", s_ir, 0);
    chk("stall_data", s_od, pix(1, 0, 0));
    fork
      band_s(3);
      begin
        s_or = 1;
        repeat (5) tick;
        chk("release5", s_ir, 0);
        tick;
        chk("release6", s_ir, 1);
      end
    join
    drain_s;

    // random backpressure over three bands
    fork
      begin
        band_s(1);
        band_s(2);
        band_s(3);
      end
      begin
        for (int i = 0; i < 150; i++) begin
          s_or = 1'($urandom_range(0, 1));
          tick;
        end
        s_or = 1;
      end
    join
    drain_s;

    // reset during row-1 drain
    band_s(2);
    repeat (6) tick;
    chk("pre_rst_row1", s_od, pix(2, 1, 0));
    rst = 1'b1;
    #1;
    chk("mid_rst_ov", s_ov, 0);
    chk("mid_rst_od", s_od, 0);
    chk("mid_rst_rdy", s_ir, 1);
    s_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick;

    // fresh band after reset, then bank 1 fill coinciding with bank 0 final fetch
    band_s(3);
    tick;
    tick;
    chk("post_rst_ov", s_ov, 1);
    chk("post_rst_first", s_od, pix(3, 0, 0));
    tick;
    tick;
    band_s(1);
    chk("coin_rdy", s_ir, 1);
    v = 0;
    for (int i = 0; i < 10; i++) begin
      v += int'(s_ov);
      tick;
    end
    chk("coin_cont", v, 10);
    chk("coin_end", s_ov, 0);
    drain_s;

    // default geometry, random data at full rate
    for (int k = 0; k < 3; k++) band_d;
    t = 0;
    while ((d_q.size() != 0 || d_ov) && t < 20000) begin
      tick;
      t++;
    end
    chk("d_drain", d_q.size(), 0);
    chk("d_count", d_cnt, 3 * 640 * 8);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/column_to_raster.md
# column_to_raster

Reassembles a raster pixel stream from vertical pixel columns. Each input beat is one column of `block_height` pixels belonging to one band of `block_height` image rows. Output is the same band row by row, one pixel per beat, with line and band markers. It is the inverse of the column-window extraction stage: it sits after per-column processing (e.g. disparity columns) and feeds raster-order consumers such as the frame writer and video output.

## Interface
- `pixel_depth`, 7, bits per pixel
- `frame_width`, 640, pixels per image row (columns per band)
- `block_height`, 8, rows per band (pixels per input column)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  input column present
- `in_ready`  out  1  column accepted on `in_valid && in_ready`
- `inColumn`  in  `block_height*pixel_depth`  slice `[pixel_depth*i +: pixel_depth]` is row i of the band (row 0 = top)
- `out_valid`  out  1  `outData` valid
- `out_ready`  in  1  pixel consumed on `out_valid && out_ready`
- `outData`  out  `pixel_depth`  raster pixel
- `out_line_end`  out  1  qualifies last pixel of a row (x = frame_width-1)
- `out_band_end`  out  1  qualifies last pixel of the band (row block_height-1, x = frame_width-1)

## Operation
- Two banks (ping-pong). Each bank holds `block_height` × `frame_width` pixels. `full[1:0]` marks banks awaiting drain.
- Writer: `wr_bank`, `wr_x` (0..frame_width-1). An accepted column writes row i at address `wr_x` of bank `wr_bank` for every i. When `wr_x == frame_width-1` is accepted, set `full[wr_bank]`, toggle `wr_bank` and clear `wr_x`.
- `in_ready = !full[wr_bank]`. This is a combinational decode of registered state; it has no path from `in_valid`.
- Reader: `rd_bank`, `rd_y` (0..block_height-1), `rd_x`. Pixel order is row 0 x 0..W-1, then row 1, and so on. The reader fetches while `full[rd_bank]` and the output register is empty or being consumed (`!out_valid || out_ready`).
- When the pixel with `rd_y = block_height-1` and `rd_x = W-1` is fetched, clear `full[rd_bank]`, toggle `rd_bank` and clear the counters.
- Counter widths are `$clog2` of their ranges, with a minimum of 1. Compare against `frame_width-1` and `block_height-1`; there is no power-of-two assumption.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `outData`=0, `out_line_end`=0, `out_band_end`=0, `full`=0, all counters 0, both bank pointers 0. Reset is asynchronous, so outputs clear without waiting for a clock edge.
- RAM read is synchronous (1 cycle), followed by an output register. The last column is accepted at edge N and `full` is set after N. The first pixel is presented after edge N+2.
- Sustained throughput is 1 pixel per cycle with `out_ready` held high. There is no bubble between rows or between banks when the next bank is already full.
- Stall: while `out_valid && !out_ready`, `outData` and both end markers hold stable. No pixel is dropped or duplicated, including pixels already inside the read pipeline (skid stage required).
- Bank release: `full` clears on the edge that fetches the final pixel. `in_ready` may rise in the following cycle.
- Simultaneous set and clear on different banks in the same edge are both applied. Same-bank set and clear is impossible because the writer cannot target a full bank.
- Both banks full: `in_ready`=0 until a bank is released.
- Reset mid-band discards all buffered data. Nothing from before reset is ever emitted.

## Structure
- Shared package `sgm_pkg`: function `clog2_min1`, and derived width constants for x and y counters.
- Sub-module `row_line_ram`: one row of one bank, `frame_width` × `pixel_depth`, one write port, one synchronous read port. Instantiate 2 × `block_height` copies.
- The top level holds the write and read FSM counters, the `full` flags and the output skid register.

## Test plan
Use `frame_width`=4, `block_height`=2, `pixel_depth`=8 unless noted.
- Reset only -> `in_ready`=1, `out_valid`=0, `outData`=0.
- Send 4 columns {row1,row0} = {0x10+x, 0x00+x} with `out_ready`=1 -> outputs 00,01,02,03,10,11,12,13. `out_line_end` is set on 03 and 13; `out_band_end` on 13 only. The first pixel appears 2 edges after the last column is accepted.
- Send 3 bands back-to-back with `out_ready`=0 -> `in_ready` drops after the 8th column. It rises the cycle after pixel 13 of band 0 is fetched, once `out_ready` is released.
- Toggle `out_ready` 1,0,1,0 randomly over 3 bands -> the output sequence exactly matches the golden raster, and `outData` is stable across stalls.
- Assert `rst` during the row-1 drain -> `out_valid` goes low immediately. After release, the next new band is emitted starting at 00 with no stale pixels.
- Make the last column of bank 1 and the final fetch of bank 0 coincide on one edge -> continuous output across the band boundary, and both `full` bits update correctly.
- Default parameters (640×8×7): stream 3 bands of random data at full rate -> the output matches the scoreboard.
